// File: rtl/commit_arb_pkg.sv
// Shared types and helpers for the commit arbiter: buffered result entry,
// source indices and the wrap-safe timestamp age compare.
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 6
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package commit_arb_pkg;
  localparam int PKG_NUM_SRC = 4;
  localparam int PKG_CID_W   = `COMMIT_ID_WIDTH;
  localparam int PKG_RA_W    = `REG_ADDR_WIDTH;
  localparam int PKG_RD_W    = 32;
  localparam int PKG_TS_W    = 32;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_DIV = 2;
  localparam int SRC_LSU = 3;

  typedef struct packed {
    logic [PKG_CID_W-1:0] cid;
    logic                 rd_we;
    logic [PKG_RA_W-1:0]  rd_addr;
    logic [PKG_RD_W-1:0]  rd_data;
    logic [PKG_TS_W-1:0]  ts;
  } commit_entry_t;

  // Modular difference: a negative result means a was issued before b.
  function automatic logic ts_older(input logic [PKG_TS_W-1:0] a,
                                    input logic [PKG_TS_W-1:0] b);
    logic [PKG_TS_W-1:0] diff;
    diff = a - b;
    return diff[PKG_TS_W-1];
  endfunction
endpackage

// File: rtl/commit_oldest_sel.sv
// Combinational oldest-of-N selector over a valid mask; on equal timestamps
// the lower index wins because only strictly older entries replace the best.
module commit_oldest_sel
  import commit_arb_pkg::*;
#(
  parameter int NUM_SRC = PKG_NUM_SRC
) (
  input  logic [NUM_SRC-1:0] i_valid,
  input  commit_entry_t      i_entry [NUM_SRC],
  output logic [NUM_SRC-1:0] o_pick,
  output logic               o_any,
  output commit_entry_t      o_entry
);
  logic          w_found;
  commit_entry_t w_best;

  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    w_best  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_valid[i] && (!w_found || ts_older(i_entry[i].ts, w_best.ts))) begin
        w_found   = 1'b1;
        w_best    = i_entry[i];
        o_pick    = '0;
        o_pick[i] = 1'b1;
      end
    end
  end

  assign o_any   = w_found;
  assign o_entry = w_best;
endmodule

// File: rtl/commit_arb.sv
// Completion arbiter: one holding slot per execution unit, retires up to two
// results per cycle oldest first onto dual commit / register-file write ports.
module commit_arb
  import commit_arb_pkg::*;
#(
  parameter int NUM_SRC = PKG_NUM_SRC,
  parameter int CID_W   = `COMMIT_ID_WIDTH,
  parameter int RA_W    = `REG_ADDR_WIDTH,
  parameter int RD_W    = 32,
  parameter int TS_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      src_valid_i,
  output logic [NUM_SRC-1:0]      src_ready_o,
  input  logic [NUM_SRC*CID_W-1:0] src_commit_id_i,
  input  logic [NUM_SRC-1:0]      src_rd_we_i,
  input  logic [NUM_SRC*RA_W-1:0] src_rd_addr_i,
  input  logic [NUM_SRC*RD_W-1:0] src_rd_data_i,
  input  logic [NUM_SRC*TS_W-1:0] src_timestamp_i,
  output logic                    commit_valid_o,
  output logic [CID_W-1:0]        commit_id_o,
  output logic                    commit_valid2_o,
  output logic [CID_W-1:0]        commit_id2_o,
  output logic                    reg_we_o,
  output logic [RA_W-1:0]         reg_waddr_o,
  output logic [RD_W-1:0]         reg_wdata_o,
  output logic                    reg2_we_o,
  output logic [RA_W-1:0]         reg2_waddr_o,
  output logic [RD_W-1:0]         reg2_wdata_o
);
  commit_entry_t        r_slot [NUM_SRC];
  logic [NUM_SRC-1:0]   r_slot_valid;
  commit_entry_t        w_in [NUM_SRC];
  logic [NUM_SRC-1:0]   w_pick0, w_pick1_raw, w_pick1, w_selected, w_accept;
  logic                 w_any0, w_any1, w_conflict, w_do1;
  commit_entry_t        w_ent0, w_ent1;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign w_in[gi].cid     = src_commit_id_i[gi*CID_W +: CID_W];
    assign w_in[gi].rd_we   = src_rd_we_i[gi];
    assign w_in[gi].rd_addr = src_rd_addr_i[gi*RA_W +: RA_W];
    assign w_in[gi].rd_data = src_rd_data_i[gi*RD_W +: RD_W];
    assign w_in[gi].ts      = src_timestamp_i[gi*TS_W +: TS_W];
  end

  commit_oldest_sel #(.NUM_SRC(NUM_SRC)) u_sel0 (
    .i_valid (r_slot_valid),
    .i_entry (r_slot),
    .o_pick  (w_pick0),
    .o_any   (w_any0),
    .o_entry (w_ent0)
  );

  commit_oldest_sel #(.NUM_SRC(NUM_SRC)) u_sel1 (
    .i_valid (r_slot_valid & ~w_pick0),
    .i_entry (r_slot),
    .o_pick  (w_pick1_raw),
    .o_any   (w_any1),
    .o_entry (w_ent1)
  );

  // Two writes to the same architectural register in one cycle would race on
  // the register file, so the younger one waits a cycle.
  assign w_conflict = w_any0 && w_any1 && w_ent0.rd_we && w_ent1.rd_we &&
                      (w_ent0.rd_addr != '0) && (w_ent0.rd_addr == w_ent1.rd_addr);
  assign w_do1      = w_any1 && !w_conflict;
  assign w_pick1    = w_do1 ? w_pick1_raw : '0;
  assign w_selected = w_pick0 | w_pick1;

  assign src_ready_o = rst ? '0 : (~r_slot_valid | w_selected);
  assign w_accept    = src_valid_i & src_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_valid <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_slot[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_accept[i]) begin
          r_slot_valid[i] <= 1'b1;
          r_slot[i]       <= w_in[i];
        end else if (w_selected[i]) begin
          r_slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid_o  <= 1'b0;
      commit_id_o     <= '0;
      reg_we_o        <= 1'b0;
      reg_waddr_o     <= '0;
      reg_wdata_o     <= '0;
      commit_valid2_o <= 1'b0;
      commit_id2_o    <= '0;
      reg2_we_o       <= 1'b0;
      reg2_waddr_o    <= '0;
      reg2_wdata_o    <= '0;
    end else begin
      commit_valid_o  <= w_any0;
      reg_we_o        <= w_any0 && w_ent0.rd_we && (w_ent0.rd_addr != '0);
      commit_valid2_o <= w_do1;
      reg2_we_o       <= w_do1 && w_ent1.rd_we && (w_ent1.rd_addr != '0);
      if (w_any0) begin
        commit_id_o <= w_ent0.cid;
        reg_waddr_o <= w_ent0.rd_addr;
        reg_wdata_o <= w_ent0.rd_data;
      end
      if (w_do1) begin
        commit_id2_o <= w_ent1.cid;
        reg2_waddr_o <= w_ent1.rd_addr;
        reg2_wdata_o <= w_ent1.rd_data;
      end
    end
  end
endmodule

// File: tb/tb_commit_arb.sv
// Randomized plus directed bench for commit_arb against an age-rank model.
module tb_commit_arb;
  import commit_arb_pkg::*;
  localparam int N   = PKG_NUM_SRC;
  localparam int CW  = PKG_CID_W;
  localparam int RAW = PKG_RA_W;
  localparam int DW  = PKG_RD_W;
  localparam int TW  = PKG_TS_W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   src_valid_i = '0;
  logic [N-1:0]   src_ready_o;
  logic [N*CW-1:0]  src_commit_id_i = '0;
  logic [N-1:0]     src_rd_we_i = '0;
  logic [N*RAW-1:0] src_rd_addr_i = '0;
  logic [N*DW-1:0]  src_rd_data_i = '0;
  logic [N*TW-1:0]  src_timestamp_i = '0;
  logic           commit_valid_o, commit_valid2_o, reg_we_o, reg2_we_o;
  logic [CW-1:0]  commit_id_o, commit_id2_o;
  logic [RAW-1:0] reg_waddr_o, reg2_waddr_o;
  logic [DW-1:0]  reg_wdata_o, reg2_wdata_o;

  commit_arb dut (
    .clk(clk), .rst(rst),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_commit_id_i(src_commit_id_i), .src_rd_we_i(src_rd_we_i),
    .src_rd_addr_i(src_rd_addr_i), .src_rd_data_i(src_rd_data_i),
    .src_timestamp_i(src_timestamp_i),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o),
    .commit_valid2_o(commit_valid2_o), .commit_id2_o(commit_id2_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .reg2_we_o(reg2_we_o), .reg2_waddr_o(reg2_waddr_o), .reg2_wdata_o(reg2_wdata_o)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // stimulus for the current cycle
  bit             dv [N];
  logic [CW-1:0]  dcid [N];
  bit             dwe [N];
  logic [RAW-1:0] da [N];
  logic [DW-1:0]  dd [N];
  logic [TW-1:0]  dts [N];

  // model: buffered entries per source and expected registered outputs
  bit             mv [N];
  logic [CW-1:0]  mcid [N];
  bit             mwe [N];
  logic [RAW-1:0] ma [N];
  logic [DW-1:0]  md [N];
  logic [TW-1:0]  mts [N];
  bit             e_cv, e_we, e_cv2, e_we2;
  logic [CW-1:0]  e_cid, e_cid2;
  logic [RAW-1:0] e_wa, e_wa2;
  logic [DW-1:0]  e_wd, e_wd2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic bit older(input int i, input int j);
    logic [TW-1:0] d;
    d = mts[i] - mts[j];
    return ($signed(d) < 0) || (mts[i] == mts[j] && i < j);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) mv[i] = 0;
    e_cv = 0; e_we = 0; e_cv2 = 0; e_we2 = 0;
    e_cid = '0; e_cid2 = '0; e_wa = '0; e_wa2 = '0; e_wd = '0; e_wd2 = '0;
  endtask

  task automatic clr_drive();
    for (int i = 0; i < N; i++) begin
      dv[i] = 0; dcid[i] = '0; dwe[i] = 0; da[i] = '0; dd[i] = '0; dts[i] = '0;
    end
  endtask

  task automatic set_src(input int s, input int cid, input bit we, input int a,
                         input logic [DW-1:0] d, input logic [TW-1:0] ts);
    dv[s] = 1; dcid[s] = CW'(cid); dwe[s] = we; da[s] = RAW'(a); dd[s] = d; dts[s] = ts;
  endtask

  task automatic check_outputs();
    chk("commit_valid", commit_valid_o, e_cv);
    chk("commit_id", commit_id_o, e_cid);
    chk("reg_we", reg_we_o, e_we);
    chk("reg_waddr", reg_waddr_o, e_wa);
    chk("reg_wdata", reg_wdata_o, e_wd);
    chk("commit_valid2", commit_valid2_o, e_cv2);
    chk("commit_id2", commit_id2_o, e_cid2);
    chk("reg2_we", reg2_we_o, e_we2);
    chk("reg2_waddr", reg2_waddr_o, e_wa2);
    chk("reg2_wdata", reg2_wdata_o, e_wd2);
  endtask

  // One clock: check ready, drive inputs, advance model, check registered outputs.
  task automatic step();
    int p0, p1, rank;
    logic [N-1:0] rdy;
    p0 = -1; p1 = -1;
    for (int i = 0; i < N; i++) begin
      if (mv[i]) begin
        rank = 0;
        for (int j = 0; j < N; j++) if (j != i && mv[j] && older(j, i)) rank++;
        if (rank == 0) p0 = i;
        else if (rank == 1) p1 = i;
      end
    end
    if (p0 >= 0 && p1 >= 0 && mwe[p0] && mwe[p1] && ma[p0] != 0 && ma[p0] == ma[p1]) p1 = -1;
    for (int i = 0; i < N; i++) rdy[i] = !mv[i] || i == p0 || i == p1;
    chk("src_ready", src_ready_o, rdy);

    for (int i = 0; i < N; i++) begin
      src_valid_i[i] = dv[i];
      src_commit_id_i[i*CW +: CW] = dcid[i];
      src_rd_we_i[i] = dwe[i];
      src_rd_addr_i[i*RAW +: RAW] = da[i];
      src_rd_data_i[i*DW +: DW] = dd[i];
      src_timestamp_i[i*TW +: TW] = dts[i];
    end

    e_cv = (p0 >= 0);
    e_we = 0;
    if (p0 >= 0) begin
      e_cid = mcid[p0]; e_wa = ma[p0]; e_wd = md[p0]; e_we = mwe[p0] && ma[p0] != 0;
    end
    e_cv2 = (p1 >= 0);
    e_we2 = 0;
    if (p1 >= 0) begin
      e_cid2 = mcid[p1]; e_wa2 = ma[p1]; e_wd2 = md[p1]; e_we2 = mwe[p1] && ma[p1] != 0;
    end
    for (int i = 0; i < N; i++) begin
      if (dv[i] && rdy[i]) begin
        mv[i] = 1; mcid[i] = dcid[i]; mwe[i] = dwe[i]; ma[i] = da[i]; md[i] = dd[i]; mts[i] = dts[i];
      end else if (i == p0 || i == p1) begin
        mv[i] = 0;
      end
    end

    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    clr_drive();
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [TW-1:0] ts_base;

  initial begin
    clr_drive();
    clear_model();
    #1;
    chk("reset_valid", commit_valid_o, 0);
    chk("reset_ready", src_ready_o, 0);
    @(posedge clk); @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("ready_after_reset", src_ready_o, 4'hF);
    check_outputs();

    // single ALU result
    clr_drive();
    set_src(SRC_ALU, 3, 1, 5, 32'hDEADBEEF, 10);
    step(); idle(1);
    chk("single_valid", commit_valid_o, 1);
    chk("single_id", commit_id_o, 3);
    chk("single_we", reg_we_o, 1);
    chk("single_waddr", reg_waddr_o, 5);
    chk("single_wdata", reg_wdata_o, 32'hDEADBEEF);
    chk("single_valid2", commit_valid2_o, 0);
    idle(2);

    // dual retire, LSU older than MUL
    clr_drive();
    set_src(SRC_MUL, 11, 1, 2, 32'h1111, 7);
    set_src(SRC_LSU, 22, 1, 9, 32'h2222, 4);
    step(); idle(1);
    chk("dual_id1", commit_id_o, 22);
    chk("dual_valid2", commit_valid2_o, 1);
    chk("dual_id2", commit_id2_o, 11);
    idle(2);

    // three-way contention
    clr_drive();
    set_src(SRC_ALU, 1, 1, 1, 32'hA, 1);
    set_src(SRC_MUL, 2, 1, 2, 32'hB, 2);
    set_src(SRC_DIV, 3, 1, 3, 32'hC, 3);
    step();
    chk("three_div_ready_held", src_ready_o[SRC_DIV], 0);
    chk("three_alu_ready", src_ready_o[SRC_ALU], 1);
    idle(1);
    chk("three_id1", commit_id_o, 1);
    chk("three_id2", commit_id2_o, 2);
    chk("three_div_ready_sel", src_ready_o[SRC_DIV], 1);
    idle(1);
    chk("three_div_id", commit_id_o, 3);
    chk("three_div_valid2", commit_valid2_o, 0);
    idle(2);

    // same-rd conflict
    clr_drive();
    set_src(SRC_DIV, 40, 1, 6, 32'h5, 5);
    set_src(SRC_ALU, 41, 1, 6, 32'h8, 8);
    step(); idle(1);
    chk("conf_id1", commit_id_o, 40);
    chk("conf_valid2", commit_valid2_o, 0);
    idle(1);
    chk("conf_next_valid", commit_valid_o, 1);
    chk("conf_next_id", commit_id_o, 41);
    chk("conf_next_valid2", commit_valid2_o, 0);
    idle(2);

    // timestamp wrap, then x0 destination
    clr_drive();
    set_src(SRC_MUL, 50, 1, 4, 32'h50, 32'hFFFFFFFE);
    set_src(SRC_ALU, 51, 1, 7, 32'h51, 32'h00000001);
    step(); idle(1);
    chk("wrap_id1", commit_id_o, 50);
    chk("wrap_id2", commit_id2_o, 51);
    clr_drive();
    set_src(SRC_LSU, 7, 1, 0, 32'h77, 20);
    step(); idle(1);
    chk("x0_valid", commit_valid_o, 1);
    chk("x0_we", reg_we_o, 0);
    idle(2);

    // reset while busy
    clr_drive();
    set_src(SRC_ALU, 60, 1, 7, 32'h60, 30);
    set_src(SRC_MUL, 61, 1, 7, 32'h61, 31);
    set_src(SRC_DIV, 62, 1, 7, 32'h62, 32);
    step(); idle(1);
    chk("midrst_pre_valid", commit_valid_o, 1);
    rst = 1;
    #1;
    chk("midrst_valid", commit_valid_o, 0);
    chk("midrst_id", commit_id_o, 0);
    chk("midrst_valid2", commit_valid2_o, 0);
    chk("midrst_ready", src_ready_o, 0);
    clear_model();
    @(posedge clk); @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("midrst_ready_after", src_ready_o, 4'hF);
    idle(4);

    // random traffic with a wrapping timestamp base
    ts_base = 32'hFFFFFF00;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        dv[i]   = ($urandom_range(0, 99) < 60);
        dcid[i] = CW'($urandom);
        dwe[i]  = ($urandom_range(0, 3) != 0);
        da[i]   = RAW'($urandom_range(0, 3));
        dd[i]   = $urandom;
        dts[i]  = ts_base - TW'($urandom_range(0, 6));
      end
      ts_base = ts_base + 1;
      step();
    end
    idle(4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/commit_arb.md
Name: commit_arb

Overview:
- Completion-side counterpart of the issue/hazard logic.
- Collects finished results from the execution units (ALU, MUL, DIV, LSU), each tagged with the commit ID and timestamp assigned at issue.
- Retires up to two results per cycle, oldest first.
- Drives the dual register-file write ports and the commit_valid/commit_id and commit_valid2/commit_id2 pairs consumed by the hazard unit to release scoreboard entries.

Parameters:
- NUM_SRC, 4: number of execution-unit result sources.
- CID_W, `COMMIT_ID_WIDTH: commit ID width.
- RA_W, `REG_ADDR_WIDTH: register address width.
- RD_W, 32: register write-data width.
- TS_W, 32: issue timestamp width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- src_valid_i  in  NUM_SRC  per-source result valid
- src_ready_o  out  NUM_SRC  per-source accept
- src_commit_id_i  in  NUM_SRC*CID_W  per-source commit ID
- src_rd_we_i  in  NUM_SRC  per-source rd write enable
- src_rd_addr_i  in  NUM_SRC*RA_W  per-source rd address
- src_rd_data_i  in  NUM_SRC*RD_W  per-source rd data
- src_timestamp_i  in  NUM_SRC*TS_W  per-source issue timestamp
- commit_valid_o  out  1  port-1 retire (older of the pair)
- commit_id_o  out  CID_W  port-1 commit ID
- commit_valid2_o  out  1  port-2 retire
- commit_id2_o  out  CID_W  port-2 commit ID
- reg_we_o, reg_waddr_o, reg_wdata_o  out  1/RA_W/RD_W  register-file write port 1
- reg2_we_o, reg2_waddr_o, reg2_wdata_o  out  1/RA_W/RD_W  register-file write port 2

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset: all buffer slots empty; every output 0; src_ready_o is all-ones once rst deasserts.
- Buffering: one holding slot per source.
  - Handshake = src_valid_i & src_ready_o.
  - src_ready_o[i] = ~slot_valid[i] | slot_selected[i]. This is a combinational path from selection; it gives back-to-back throughput of 1 per source.
- Age compare: A is older than B iff $signed(A.ts - B.ts) < 0, in TS_W-bit modular arithmetic, so wrap-around is handled. On a timestamp tie, the lower source index is older.
- Selection, each cycle, over valid slots:
  - pick0 = oldest slot.
  - pick1 = oldest remaining slot.
  - pick1 is suppressed if pick0 and pick1 both have rd_we=1 and the same nonzero rd_addr. The younger slot stays buffered for a later cycle.
- Output registers load at the clock edge; selected slots are cleared at that same edge.
  - pick0 drives commit/reg port 1.
  - pick1 drives commit/reg port 2.
  - When nothing is picked, the valid outputs are 0.
- Latency: handshake in cycle t -> commit_valid_o or commit_valid2_o high in cycle t+2, if not blocked by older entries.
- Port order: commit_valid2_o is never high unless commit_valid_o is high in the same cycle. Port 1 always carries the older entry.
- rd = x0, or rd_we = 0: commit is still reported; the corresponding reg*_we_o is 0.
- Registered valid and we outputs are single-cycle pulses per retired entry; data and ID hold their value when valid is low.
- A slot filled and selected in the same cycle is not allowed: selection sees only registered slot state.
- Simultaneous accept and retire on one source: the slot is overwritten by the new entry.
- Reset mid-operation: buffered entries are discarded, outputs go to 0 immediately (async), and no commit pulse is emitted.
- Timestamp ordering is a correctness requirement: issue never has more than 2^(TS_W-1) in flight, so the modular compare is valid.

Decomposition:
- Shared package:
  - commit_entry_t struct: cid, rd_we, rd_addr, rd_data, ts.
  - Source-index constants: SRC_ALU=0, SRC_MUL=1, SRC_DIV=2, SRC_LSU=3.
  - ts_older() compare function.
- Sub-module commit_oldest_sel: combinational oldest-of-N over a valid mask plus entries. Returns a one-hot pick and the entry. Instantiated twice: the second instance takes a mask with pick0 removed.

Test Plan:
- Single result: ALU, cid=3, rd=5, data=0xDEADBEEF, ts=10, handshake at t -> at t+2, commit_valid_o=1, commit_id_o=3, reg_we_o=1, reg_waddr_o=5; commit_valid2_o=0.
- Dual retire: MUL (ts=7, rd=2) and LSU (ts=4, rd=9) in the same cycle -> port 1 carries the LSU cid, port 2 the MUL cid, same cycle.
- Three-way contention: ALU ts=1, MUL ts=2, DIV ts=3 simultaneously -> ALU/MUL retire at t+2 and DIV at t+3; src_ready_o[DIV] stays 0 while its slot is held, with ready following ~slot_valid | slot_selected.
- Same-rd conflict: DIV ts=5 rd=6 and ALU ts=8 rd=6 -> DIV retires alone; ALU retires the next cycle on port 1; never both in one cycle.
- Wrap and x0: MUL ts=0xFFFFFFFE and ALU ts=0x00000001 -> MUL on port 1. An entry with rd=0, rd_we=1 -> commit pulse with reg_we_o=0.
- Reset mid-op: assert rst with 3 slots full -> outputs 0 in the same cycle; after release there are no stale commits and src_ready_o=all-ones.
